// File: rtl/rv32v_seq_reduction_unit_if.sv
// Shared reduction-op encoding plus the handshake bundle between a requester
// (master) and the sequential reduction unit (slave).
package rv32v_seq_reduction_pkg;

  // Encodings 6 and 7 are deliberately left unassigned; the unit flags them
  // with a poison result instead of silently aliasing another op.
  typedef enum logic [2:0] {
    VALU_ADD = 3'd0,
    VALU_MAX = 3'd1,
    VALU_MIN = 3'd2,
    VALU_AND = 3'd3,
    VALU_OR  = 3'd4,
    VALU_XOR = 3'd5
  } valuop_t;

endpackage

interface rv32v_seq_reduction_unit_if #(
  parameter int NLANES = 4
);
  import rv32v_seq_reduction_pkg::*;

  logic                     start;
  valuop_t                  valuop;
  logic                     vopunsigned;
  logic [31:0]              seed;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [NLANES-1:0][31:0]  vdat_in;
  logic [NLANES-1:0]        vmask_in;
  logic                     abort;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              vdat_out;
  logic                     busy;

  modport master (
    output start, valuop, vopunsigned, seed,
    output in_valid, in_last, vdat_in, vmask_in, abort, out_ready,
    input  in_ready, out_valid, vdat_out, busy
  );

  modport slave (
    input  start, valuop, vopunsigned, seed,
    input  in_valid, in_last, vdat_in, vmask_in, abort, out_ready,
    output in_ready, out_valid, vdat_out, busy
  );

endinterface

// File: rtl/rv32v_seq_reduction_unit.sv
// Sequential vector reduction: folds a stream of NLANES-wide beats into a
// 32-bit scalar, starting from a seed. Each beat is first reduced by a
// balanced tree of masked lanes, then merged into the accumulator, giving
// one beat per cycle.
module rv32v_seq_reduction_unit
  import rv32v_seq_reduction_pkg::*;
#(
  parameter int NLANES = 4
) (
  input logic                       CLK,
  input logic                       nRST,
  rv32v_seq_reduction_unit_if.slave bus
);

  if ((NLANES < 2) || (NLANES > 16) || ((NLANES & (NLANES - 1)) != 0)) begin : g_bad_nlanes
    $error("NLANES must be a power of two between 2 and 16");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] POISON = 32'hBAD1BAD1;

  state_t      state;
  logic [31:0] acc;
  valuop_t     op_q;
  logic        uns_q;
  logic [31:0] beat_result;

  // Value that leaves the other operand unchanged, substituted for masked lanes.
  function automatic logic [31:0] identity(input valuop_t op, input logic uns);
    logic [31:0] r;
    // NOTE: every path assigns r up front, so no storage is implied here or in
    // any combinational logic that calls this.
    r = '0;
    case (op)
      VALU_AND: r = 32'hFFFF_FFFF;
      VALU_MAX: r = uns ? 32'h0000_0000 : 32'h8000_0000;
      VALU_MIN: r = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Two-operand step of the reduction; unsupported encodings poison the result.
  function automatic logic [31:0] combine(input valuop_t op, input logic uns,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = POISON;
    case (op)
      VALU_ADD: r = a + b;
      VALU_AND: r = a & b;
      VALU_OR:  r = a | b;
      VALU_XOR: r = a ^ b;
      VALU_MAX: r = (uns ? (a > b) : ($signed(a) > $signed(b))) ? a : b;
      VALU_MIN: r = (uns ? (a < b) : ($signed(a) < $signed(b))) ? a : b;
      default:  r = POISON;
    endcase
    return r;
  endfunction

  // Heap-ordered tree: leaves at NLANES-1..2*NLANES-2, node i combines its
  // children 2i+1 and 2i+2, so a power-of-two lane count gives log2(NLANES)
  // equal-depth levels.
  function automatic logic [31:0] reduce_tree(input logic [NLANES-1:0][31:0] lanes,
                                              input logic [NLANES-1:0]       mask,
                                              input valuop_t                 op,
                                              input logic                    uns);
    logic [31:0] node [2*NLANES-1];
    for (int i = 0; i < 2 * NLANES - 1; i++) node[i] = '0;
    for (int i = 0; i < NLANES; i++) begin
      node[NLANES-1+i] = mask[i] ? lanes[i] : identity(op, uns);
    end
    for (int i = NLANES - 2; i >= 0; i--) begin
      node[i] = combine(op, uns, node[2*i+1], node[2*i+2]);
    end
    return node[0];
  endfunction

  // Next accumulator value for the beat currently on the input.
  always_comb begin
    beat_result = combine(op_q, uns_q, acc,
                          reduce_tree(bus.vdat_in, bus.vmask_in, op_q, uns_q));
  end

  // Control FSM and accumulator; abort overrides every other transition.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: state elements update with <= so every read in this block sees
      // the pre-edge value, independent of statement order.
      state <= S_IDLE;
      acc   <= '0;
      op_q  <= VALU_ADD;
      uns_q <= 1'b0;
    end else if (bus.abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_ACCUM;
            acc   <= bus.seed;
            op_q  <= bus.valuop;
            uns_q <= bus.vopunsigned;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            // An all-masked beat contributes nothing, even for a poisoned op.
            if (bus.vmask_in != '0) acc <= beat_result;
            if (bus.in_last) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs are pure decodes of registered state, so they follow reset
  // immediately and never glitch on input activity.
  assign bus.in_ready  = (state == S_ACCUM);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.vdat_out  = (state == S_DONE) ? acc : '0;

endmodule

// File: doc/rv32v_seq_reduction_unit.md
RV32V_SEQ_REDUCTION_UNIT -- requirements
Module: rv32v_seq_reduction_unit

Interface
REQ-001 Parameter NLANES, default 4, lane count per beat; SHALL be a power of two, 2..16.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin a reduction; sampled only in IDLE.
REQ-005 valuop  input  valuop_t  reduction op (ADD, MAX, MIN, AND, OR, XOR); sampled with start.
REQ-006 vopunsigned  input  1  unsigned compare for MAX/MIN; sampled with start.
REQ-007 seed  input  32  scalar initial value (vs1[0]); sampled with start.
REQ-008 in_valid  input  1  beat valid.
REQ-009 in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-010 in_last  input  1  marks final beat; qualified by in_valid.
REQ-011 vdat_in  input  NLANES x word_t  lane data of current beat.
REQ-012 vmask_in  input  NLANES  lane enables; 0 = lane excluded.
REQ-013 abort  input  1  cancel reduction in progress.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  result consumed when out_valid & out_ready.
REQ-016 vdat_out  output  32  reduction result.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, ACCUM, DONE; in_ready = (state==ACCUM); out_valid = (state==DONE); vdat_out = accumulator in DONE, 0 otherwise.
REQ-019 IDLE & start: next cycle ACCUM; accumulator <= seed; valuop/vopunsigned latched and used for the whole reduction.
REQ-020 start outside IDLE SHALL be ignored, including DONE with out_ready high.
REQ-021 Excluded lanes SHALL take the op identity: ADD/OR/XOR 0; AND all-ones; MAX unsigned 0, signed 0x80000000; MIN unsigned 0xFFFFFFFF, signed 0x7FFFFFFF.
REQ-022 Accepted beat: accumulator <= op(accumulator, balanced log2(NLANES)-level tree of masked lanes) in the same edge; single-cycle throughput, one beat per cycle.
REQ-023 ADD SHALL wrap modulo 2^32; MAX/MIN compare signed unless latched vopunsigned.
REQ-024 Latched op outside the supported set: accumulator <= 32'hBAD1BAD1 on each accepted beat.
REQ-025 Beat with vmask_in all zero SHALL leave the accumulator unchanged.
REQ-026 Accepted beat with in_last: next cycle DONE; in_valid low in ACCUM: hold state and accumulator.
REQ-027 DONE: out_valid and vdat_out held stable until out_ready; out_valid & out_ready -> IDLE next cycle.
REQ-028 abort in any state: IDLE next cycle; priority over start, beat acceptance and out_ready; result discarded, no out_valid.
REQ-029 At least one beat (with in_last) SHALL complete every reduction; no zero-beat path.

Reset
REQ-030 nRST low: immediately state=IDLE, accumulator=0, latched op=VALU_ADD, latched vopunsigned=0; hence in_ready=0, out_valid=0, busy=0, vdat_out=0.
REQ-031 Reset mid-reduction SHALL discard all progress; first edge after nRST release behaves as IDLE.

Verification (NLANES=4)
REQ-032 ADD, seed 10; beat {1,2,3,4} mask 1111; beat {5,6,7,8} mask 0101 last -> out_valid one cycle after last beat, vdat_out=32.
REQ-033 Signed MAX, seed 0xFFFFFFF0; single beat {0x80000000,0xFFFFFFFE,5,7} mask 0111 last -> vdat_out=5; same with vopunsigned=1 -> 0xFFFFFFFE.
REQ-034 MINU, seed 0x1234; beat mask 0000 last -> 0x1234; ADD seed 0xFFFFFFFF, beat {1,0,0,0} mask 0001 -> 0x00000000.
REQ-035 AND, beat result in DONE, out_ready low 3 cycles -> out_valid=1, vdat_out stable, in_ready=0, start ignored; out_ready high -> IDLE next cycle.
REQ-036 abort after first of three beats -> IDLE next cycle, out_valid never asserted; new start with seed 7, OR beat {8,0,0,0} last -> 15.
REQ-037 nRST asserted in DONE -> out_valid and busy 0 without a clock edge; post-release start operates normally.
